gp_reg_xfer_ctrl: RTL and testbench
===================================

Name: gp_reg_xfer_ctrl

Overview:
- Bus-side initiator for the general-purpose register file.
- Sequences a register-to-register move over the shared tri-state data bus:
  - asserts the source register's active-low output enable,
  - pulses the destination register's write clock while the bus is stable,
  - releases the bus.
- Captures the transferred byte and reports completion with a busy/done handshake.
- Drives the n_oe_a/w_clk inputs of every gp register. Sits between the control decoder and the register file.

Parameters:
- N_REGS, 4, number of gp registers served; one n_oe and one w_clk line each.
- SEL_W, 2, width of the src/dst select fields; must satisfy 2**SEL_W >= N_REGS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous active-low reset.
- req  input  1  transfer request; sampled only in IDLE.
- src  input  SEL_W  index of the register driving the bus.
- dst  input  SEL_W  index of the register to be written.
- bus_in  input  8  shared data bus, as seen by the controller.
- n_oe  output  N_REGS  active-low output enables; at most one bit low.
- w_clk  output  N_REGS  register write clocks; the rising edge latches the bus.
- data_q  output  8  byte captured during the last completed transfer.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse on completion.
- err  output  1  one-cycle pulse when a request is rejected.

Behaviour:
- All outputs come from flops; no combinational path from inputs to n_oe or w_clk, so strobes are glitch-free.
- Reset (n_rst=0, asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, n_oe all 1, w_clk all 0, data_q=8'h00, busy=0, done=0, err=0.
  - A transfer cut by reset is abandoned and is not resumed.
- States: IDLE -> DRIVE -> LATCH -> HOLD -> IDLE.
- IDLE:
  - busy=0, n_oe all 1, w_clk all 0.
  - On an edge with req=1, the request is validated.
  - A request is invalid if src>=N_REGS, dst>=N_REGS, or src==dst.
  - Invalid request: err=1 for the next cycle, state stays IDLE, no strobe asserted.
  - Valid request: src/dst are latched internally; next state is DRIVE.
- DRIVE (1 cycle): n_oe[src]=0, busy=1. Gives the bus one full cycle to settle.
- LATCH (1 cycle):
  - n_oe[src]=0, w_clk[dst]=1 (rising edge into the destination register).
  - data_q <= bus_in on the edge leaving LATCH.
- HOLD (1 cycle): w_clk[dst]=0, n_oe[src]=0. Holds the bus past the write edge.
- Return to IDLE: n_oe all 1, busy=0, done=1 for exactly one cycle.
- Latency: req sampled at edge 0 -> n_oe[src] low after edge 0 -> w_clk[dst] high after edge 1 -> w_clk low and data_q valid after edge 2 -> done=1 and bus released after edge 3.
- Back-to-back: a req sampled on the same edge that done is high is accepted, so transfers repeat every 4 cycles.
- req, src and dst changes while busy=1 are ignored; latched src/dst are used throughout the transfer.
- done and err are never high in the same cycle.
- Invariants:
  - At most one n_oe bit low at any time.
  - At most one w_clk bit high at any time.
  - w_clk[i] is never high while n_oe[i] is low.

Test Plan:
- Reset then idle: n_rst=0 -> n_oe=4'b1111, w_clk=4'b0000, data_q=8'h00, busy=0. Release reset, req=0 for 3 cycles -> outputs unchanged.
- Basic move: req=1, src=1, dst=2, bus_in=8'hc3 ->
  - after edge 0: n_oe=4'b1101;
  - after edge 1: w_clk=4'b0100;
  - after edge 2: w_clk=0, data_q=8'hc3;
  - after edge 3: n_oe=4'b1111, done=1 for one cycle.
- Input churn while busy: start src=0, dst=3; change to src=2, dst=1, req=1 during DRIVE ->
  - strobes still use n_oe[0] and w_clk[3];
  - new request taken only on the done cycle; second transfer uses n_oe[2] and w_clk[1].
- Rejections: req with src=dst=1 -> err=1 one cycle, no strobes, busy=0. With N_REGS=3, src=3 -> same.
- Mid-transfer reset: n_rst=0 during LATCH with bus_in=8'ha5 ->
  - n_oe=4'b1111 and w_clk=0 immediately;
  - data_q=8'h00; no done pulse after reset is released.
- Back-to-back: two valid requests, bus_in=8'h5a then 8'h3c -> done pulses 4 cycles apart, data_q=8'h5a then 8'h3c.

Source files
------------

// File: rtl/gp_reg_xfer_ctrl_if.sv
// Bus bundle between the control decoder and the gp register transfer controller.
// The master modport is the controller; the slave modport is the decoder/register-file side.
interface gp_reg_xfer_ctrl_if #(
  parameter int N_REGS = 4,
  parameter int SEL_W  = 2
);
  logic              req;
  logic [SEL_W-1:0]  src;
  logic [SEL_W-1:0]  dst;
  logic [7:0]        bus_in;
  logic [N_REGS-1:0] n_oe;
  logic [N_REGS-1:0] w_clk;
  logic [7:0]        data_q;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  req, src, dst, bus_in,
    output n_oe, w_clk, data_q, busy, done, err
  );

  modport slave (
    output req, src, dst, bus_in,
    input  n_oe, w_clk, data_q, busy, done, err
  );
endinterface

// File: rtl/gp_reg_xfer_ctrl.sv
// Register-to-register move sequencer for the gp register file: drives the source
// output enable, strobes the destination write clock, captures the byte, reports done.
module gp_reg_xfer_ctrl #(
  parameter int N_REGS = 4,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  gp_reg_xfer_ctrl_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [SEL_W:0] NREGS_W = (SEL_W + 1)'(N_REGS);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  src_q, src_d;
  logic [SEL_W-1:0]  dst_q, dst_d;
  logic [N_REGS-1:0] n_oe_q, n_oe_d;
  logic [N_REGS-1:0] w_clk_q, w_clk_d;
  logic [7:0]        data_q_q, data_q_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_ok;

  // A request is usable only if both indices exist and name different registers.
  assign req_ok = ({1'b0, bus.src} < NREGS_W) &&
                  ({1'b0, bus.dst} < NREGS_W) &&
                  (bus.src != bus.dst);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      n_oe_q   <= '1;
      w_clk_q  <= '0;
      data_q_q <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      n_oe_q   <= n_oe_d;
      w_clk_q  <= w_clk_d;
      data_q_q <= data_q_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req && req_ok) begin
          state_d = DRIVE;
          src_d   = bus.src;
          dst_d   = bus.dst;
        end
      end
      DRIVE:   state_d = LATCH;
      LATCH:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output leaves a flop.
  always_comb begin
    n_oe_d   = '1;
    w_clk_d  = '0;
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == HOLD);
    err_d    = (state_q == IDLE) && bus.req && !req_ok;
    data_q_d = (state_q == LATCH) ? bus.bus_in : data_q_q;
    for (int i = 0; i < N_REGS; i++) begin
      if ((state_d != IDLE) && (src_d == SEL_W'(i))) begin
        n_oe_d[i] = 1'b0;
      end
      if ((state_d == LATCH) && (dst_d == SEL_W'(i))) begin
        w_clk_d[i] = 1'b1;
      end
    end
  end

  assign bus.n_oe   = n_oe_q;
  assign bus.w_clk  = w_clk_q;
  assign bus.data_q = data_q_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_gp_reg_xfer_ctrl.sv
// Directed bench for gp_reg_xfer_ctrl: a 4-register instance for the main sequences
// and a 3-register instance for out-of-range index rejection.
module tb_gp_reg_xfer_ctrl;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_errors;
  logic done_seen;

  gp_reg_xfer_ctrl_if #(.N_REGS(4), .SEL_W(2)) xif ();
  gp_reg_xfer_ctrl_if #(.N_REGS(3), .SEL_W(2)) xif3 ();

  gp_reg_xfer_ctrl #(.N_REGS(4), .SEL_W(2)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (xif)
  );

  gp_reg_xfer_ctrl #(.N_REGS(3), .SEL_W(2)) u_dut3 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (xif3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later; invariants checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_one_oe", 32'($countones(~xif.n_oe) <= 1), 32'd1);
    check("inv_one_wclk", 32'($countones(xif.w_clk) <= 1), 32'd1);
    check("inv_wclk_vs_oe", 32'(|(xif.w_clk & ~xif.n_oe)), 32'd0);
    check("inv_done_err", 32'(xif.done & xif.err), 32'd0);
  endtask

  task automatic set_req(input logic r, input logic [1:0] s, input logic [1:0] d);
    xif.req = r;
    xif.src = s;
    xif.dst = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_rst    = 1'b0;
    set_req(1'b0, 2'd0, 2'd0);
    xif.bus_in  = 8'h00;
    xif3.req    = 1'b0;
    xif3.src    = 2'd0;
    xif3.dst    = 2'd0;
    xif3.bus_in = 8'h00;

    // Reset and idle
    tick();
    tick();
    check("rst_n_oe", 32'(xif.n_oe), 32'hf);
    check("rst_w_clk", 32'(xif.w_clk), 32'h0);
    check("rst_data_q", 32'(xif.data_q), 32'h00);
    check("rst_busy", 32'(xif.busy), 32'd0);
    check("rst_done", 32'(xif.done), 32'd0);
    check("rst_err", 32'(xif.err), 32'd0);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_n_oe", 32'(xif.n_oe), 32'hf);
      check("idle_w_clk", 32'(xif.w_clk), 32'h0);
      check("idle_busy", 32'(xif.busy), 32'd0);
    end

    // Basic move 1 -> 2
    set_req(1'b1, 2'd1, 2'd2);
    xif.bus_in = 8'hc3;
    tick();
    set_req(1'b0, 2'd0, 2'd0);
    check("mv_e0_n_oe", 32'(xif.n_oe), 32'hd);
    check("mv_e0_w_clk", 32'(xif.w_clk), 32'h0);
    check("mv_e0_busy", 32'(xif.busy), 32'd1);
    tick();
    check("mv_e1_n_oe", 32'(xif.n_oe), 32'hd);
    check("mv_e1_w_clk", 32'(xif.w_clk), 32'h4);
    tick();
    check("mv_e2_n_oe", 32'(xif.n_oe), 32'hd);
    check("mv_e2_w_clk", 32'(xif.w_clk), 32'h0);
    check("mv_e2_data_q", 32'(xif.data_q), 32'hc3);
    check("mv_e2_done", 32'(xif.done), 32'd0);
    tick();
    check("mv_e3_n_oe", 32'(xif.n_oe), 32'hf);
    check("mv_e3_done", 32'(xif.done), 32'd1);
    check("mv_e3_busy", 32'(xif.busy), 32'd0);
    tick();
    check("mv_e4_done", 32'(xif.done), 32'd0);
    check("mv_e4_data_q", 32'(xif.data_q), 32'hc3);

    // Input churn while busy, then second transfer taken on the done cycle
    set_req(1'b1, 2'd0, 2'd3);
    xif.bus_in = 8'h11;
    tick();
    check("ch_e0_n_oe", 32'(xif.n_oe), 32'he);
    set_req(1'b1, 2'd2, 2'd1);
    xif.bus_in = 8'h22;
    tick();
    check("ch_e1_n_oe", 32'(xif.n_oe), 32'he);
    check("ch_e1_w_clk", 32'(xif.w_clk), 32'h8);
    tick();
    check("ch_e2_n_oe", 32'(xif.n_oe), 32'he);
    check("ch_e2_data_q", 32'(xif.data_q), 32'h22);
    tick();
    check("ch_e3_done", 32'(xif.done), 32'd1);
    check("ch_e3_n_oe", 32'(xif.n_oe), 32'hf);
    tick();
    set_req(1'b0, 2'd0, 2'd0);
    check("ch_e4_n_oe", 32'(xif.n_oe), 32'hb);
    check("ch_e4_busy", 32'(xif.busy), 32'd1);
    tick();
    check("ch_e5_w_clk", 32'(xif.w_clk), 32'h2);
    tick();
    tick();
    check("ch_e7_done", 32'(xif.done), 32'd1);
    tick();

    // Rejections: src == dst on the 4-reg unit, index 3 on the 3-reg unit
    set_req(1'b1, 2'd1, 2'd1);
    xif3.req = 1'b1;
    xif3.src = 2'd3;
    xif3.dst = 2'd0;
    tick();
    set_req(1'b0, 2'd0, 2'd0);
    xif3.req = 1'b0;
    check("rej_err", 32'(xif.err), 32'd1);
    check("rej_busy", 32'(xif.busy), 32'd0);
    check("rej_n_oe", 32'(xif.n_oe), 32'hf);
    check("rej_w_clk", 32'(xif.w_clk), 32'h0);
    check("rej3_err", 32'(xif3.err), 32'd1);
    check("rej3_n_oe", 32'(xif3.n_oe), 32'h7);
    check("rej3_busy", 32'(xif3.busy), 32'd0);
    tick();
    check("rej_err_clear", 32'(xif.err), 32'd0);
    check("rej3_err_clear", 32'(xif3.err), 32'd0);
    check("rej_no_strobe", 32'(xif.n_oe), 32'hf);

    // Mid-transfer asynchronous reset during LATCH
    set_req(1'b1, 2'd2, 2'd0);
    xif.bus_in = 8'ha5;
    tick();
    set_req(1'b0, 2'd0, 2'd0);
    tick();
    check("mr_latch_w_clk", 32'(xif.w_clk), 32'h1);
    #2;
    n_rst = 1'b0;
    #1;
    check("mr_n_oe", 32'(xif.n_oe), 32'hf);
    check("mr_w_clk", 32'(xif.w_clk), 32'h0);
    check("mr_data_q", 32'(xif.data_q), 32'h00);
    check("mr_busy", 32'(xif.busy), 32'd0);
    tick();
    n_rst = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      done_seen = done_seen | xif.done;
    end
    check("mr_no_done", 32'(done_seen), 32'd0);
    check("mr_data_q_after", 32'(xif.data_q), 32'h00);

    // Back-to-back transfers 0 -> 1 then 3 -> 2
    set_req(1'b1, 2'd0, 2'd1);
    xif.bus_in = 8'h5a;
    tick();
    tick();
    tick();
    check("bb_e2_data_q", 32'(xif.data_q), 32'h5a);
    set_req(1'b1, 2'd3, 2'd2);
    xif.bus_in = 8'h3c;
    tick();
    check("bb_e3_done", 32'(xif.done), 32'd1);
    check("bb_e3_data_q", 32'(xif.data_q), 32'h5a);
    tick();
    set_req(1'b0, 2'd0, 2'd0);
    check("bb_e4_done", 32'(xif.done), 32'd0);
    check("bb_e4_n_oe", 32'(xif.n_oe), 32'h7);
    tick();
    check("bb_e5_w_clk", 32'(xif.w_clk), 32'h4);
    check("bb_e5_done", 32'(xif.done), 32'd0);
    tick();
    check("bb_e6_data_q", 32'(xif.data_q), 32'h3c);
    check("bb_e6_done", 32'(xif.done), 32'd0);
    tick();
    check("bb_e7_done", 32'(xif.done), 32'd1);
    check("bb_e7_n_oe", 32'(xif.n_oe), 32'hf);
    tick();
    check("bb_e8_done", 32'(xif.done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
